thread_sched: RTL and testbench

Barrel-thread scheduler for the multithreaded RISC-V pipeline.
- Drives the fetch-side thread index. This is the read address of the per-thread PC storage.
- Drives the execute-side thread index. This is the write address of the same storage. It is the fetch index delayed by EXE_STAGE cycles.
- Keeps a per-thread active mask, updated by halt and wake requests, and qualifies each issue slot with a valid bit.
- Reports when the pipeline has filled after reset.

---
 rtl/thread_sched.sv | 185 ++++++++++++++++++
 tb/tb_thread_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/thread_sched.sv
// rtl/thread_sched.sv - barrel-thread scheduler: fetch/execute thread indices, active mask, pipeline warm-up
//
// Purpose:
//   Rotates a thread index across NUM_THREADS hardware threads, one step per cycle.
//   The fetch-side index is the read address of the per-thread PC storage. The same
//   index, delayed by EXE_STAGE cycles, is the execute-side write address. A
//   per-thread active mask qualifies every issue slot. The mask is cleared by halt
//   requests and set by wake requests. A warm-up counter reports when the pipeline
//   has filled after reset.
//
// Ports:
//   clk                     clock, all logic on posedge
//   reset                   synchronous active-high reset
//   i_halt_valid            request to deactivate i_halt_thread
//   i_halt_thread           thread to deactivate
//   i_wake_valid            request to activate i_wake_thread
//   i_wake_thread           thread to activate
//   o_thread_index_counter  fetch-stage thread index
//   o_thread_index_execute  execute-stage thread index (fetch index delayed EXE_STAGE cycles)
//   o_valid_fetch           fetch slot belongs to an active thread
//   o_valid_execute         execute slot is valid (forced 0 until pipeline ready)
//   o_pipeline_ready        pipeline fill complete after reset
//   o_active_mask           registered per-thread active bits
//
// Configuration macro:
//   SINGLE_THREAD_BOOT_EN   when defined, only thread 0 is active out of reset;
//                           otherwise every thread boots active.

module thread_sched #(
    parameter int NUM_THREADS = 16,
    parameter int EXE_STAGE   = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_halt_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] i_halt_thread,
    input  logic                           i_wake_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] i_wake_thread,
    output logic [$clog2(NUM_THREADS)-1:0] o_thread_index_counter,
    output logic [$clog2(NUM_THREADS)-1:0] o_thread_index_execute,
    output logic                           o_valid_fetch,
    output logic                           o_valid_execute,
    output logic                           o_pipeline_ready,
    output logic [NUM_THREADS-1:0]         o_active_mask
);

    localparam int TW = $clog2(NUM_THREADS);
    localparam int WW = $clog2(EXE_STAGE + 2);

    localparam logic [TW-1:0] LAST_THREAD = TW'(NUM_THREADS - 1);
    localparam logic [WW-1:0] WARM_DONE   = WW'(EXE_STAGE + 1);

`ifdef SINGLE_THREAD_BOOT_EN
    localparam logic [NUM_THREADS-1:0] MASK_RESET = NUM_THREADS'(1);
`else
    localparam logic [NUM_THREADS-1:0] MASK_RESET = '1;
`endif

    // ------------------------------------------------------------------
    // Fetch-side thread counter
    // ------------------------------------------------------------------
    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Explicit compare so non-power-of-2 thread counts wrap correctly.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_THREAD) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Active mask
    // ------------------------------------------------------------------
    logic [NUM_THREADS-1:0] mask_q;
    logic [NUM_THREADS-1:0] mask_d;
    logic                   halt_ok;
    logic                   wake_ok;

    // Indices beyond the thread count are dropped rather than aliased.
    assign halt_ok = i_halt_valid && (32'(i_halt_thread) < NUM_THREADS);
    assign wake_ok = i_wake_valid && (32'(i_wake_thread) < NUM_THREADS);

    // Wake is applied after halt so a simultaneous halt+wake of the same
    // thread leaves it active and a wakeup is never lost.
    always_comb begin
        mask_d = mask_q;
        if (halt_ok) begin
            mask_d[i_halt_thread] = 1'b0;
        end
        if (wake_ok) begin
            mask_d[i_wake_thread] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= MASK_RESET;
        end else begin
            mask_q <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch valid
    // ------------------------------------------------------------------
    logic valid_fetch;

    assign valid_fetch = mask_q[cnt_q] & ~reset;

    // ------------------------------------------------------------------
    // Fetch-to-execute delay line
    // ------------------------------------------------------------------
    // Slots already in flight keep the valid bit they were issued with. A
    // halt therefore only suppresses future fetch slots of that thread.
    logic [TW-1:0]        dl_idx_q [EXE_STAGE];
    logic [EXE_STAGE-1:0] dl_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < EXE_STAGE; i++) begin
                dl_idx_q[i] <= '0;
            end
            dl_vld_q <= '0;
        end else begin
            dl_idx_q[0] <= cnt_q;
            dl_vld_q[0] <= valid_fetch;
            for (int i = 1; i < EXE_STAGE; i++) begin
                dl_idx_q[i] <= dl_idx_q[i-1];
                dl_vld_q[i] <= dl_vld_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Warm-up tracking
    // ------------------------------------------------------------------
    logic [WW-1:0] warm_q;
    logic [WW-1:0] warm_d;
    logic          ready_q;
    logic          ready_d;

    // The counter saturates at EXE_STAGE+1. Ready is registered one cycle
    // after saturation, so it rises on the (EXE_STAGE+2)-th edge after
    // reset release and then holds.
    always_comb begin
        warm_d  = warm_q;
        ready_d = ready_q;
        if (warm_q == WARM_DONE) begin
            ready_d = 1'b1;
        end else begin
            warm_d = warm_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            ready_q <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_thread_index_counter = cnt_q;
    assign o_thread_index_execute = dl_idx_q[EXE_STAGE-1];
    assign o_valid_fetch          = valid_fetch;
    assign o_valid_execute        = dl_vld_q[EXE_STAGE-1] & ready_q;
    assign o_pipeline_ready       = ready_q;
    assign o_active_mask          = mask_q;

endmodule

// File: tb/tb_thread_sched.sv
// tb/tb_thread_sched.sv - self-checking bench for thread_sched
module tb_thread_sched;

    localparam int N  = 16;
    localparam int E  = 7;
    localparam int TW = $clog2(N);

`ifdef SINGLE_THREAD_BOOT_EN
    localparam bit [N-1:0] BOOT = 16'h0001;
`else
    localparam bit [N-1:0] BOOT = 16'hFFFF;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hv = 1'b0;
    logic          wv = 1'b0;
    logic [TW-1:0] ht = '0;
    logic [TW-1:0] wt = '0;
    logic [TW-1:0] idx_f;
    logic [TW-1:0] idx_x;
    logic          vf;
    logic          vx;
    logic          rdy;
    logic [N-1:0]  mask;

    always #5 clk = ~clk;

    thread_sched #(.NUM_THREADS(N), .EXE_STAGE(E)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_halt_valid           (hv),
        .i_halt_thread          (ht),
        .i_wake_valid           (wv),
        .i_wake_thread          (wt),
        .o_thread_index_counter (idx_f),
        .o_thread_index_execute (idx_x),
        .o_valid_fetch          (vf),
        .o_valid_execute        (vx),
        .o_pipeline_ready       (rdy),
        .o_active_mask          (mask)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: cycles since reset release, mask as a bit vector, and
    // a history of every issued fetch slot (index, valid).
    bit [N-1:0] m_mask = BOOT;
    int         m_c = 0;
    int         h_idx[$];
    bit         h_vld[$];

    function automatic int e_cnt();
        return m_c % N;
    endfunction

    function automatic bit e_vf();
        return !reset && m_mask[m_c % N];
    endfunction

    function automatic bit e_rdy();
        return m_c >= E + 2;
    endfunction

    function automatic int e_xi();
        return (m_c >= E) ? h_idx[m_c - E] : 0;
    endfunction

    function automatic bit e_xv();
        return e_rdy() && (m_c >= E) && h_vld[m_c - E];
    endfunction

    task automatic step(input bit rst, input bit h, input int htn, input bit w, input int wtn);
        reset = rst;
        hv    = h;
        ht    = TW'(htn);
        wv    = w;
        wt    = TW'(wtn);
        @(posedge clk);
        if (rst) begin
            m_c    = 0;
            m_mask = BOOT;
            h_idx.delete();
            h_vld.delete();
        end else begin
            h_idx.push_back(m_c % N);
            h_vld.push_back(m_mask[m_c % N]);
            m_c++;
            if (h) m_mask[htn] = 1'b0;
            if (w) m_mask[wtn] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (idx_f !== '0) begin errors++; $display("FAIL reset_counter: got %0d expected 0", idx_f); end
        checks++; if (mask !== BOOT) begin errors++; $display("FAIL reset_mask: got %h expected %h", mask, BOOT); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", rdy); end
        checks++; if (vx !== 1'b0) begin errors++; $display("FAIL reset_vexe: got %0b expected 0", vx); end
        checks++; if (vf !== 1'b0) begin errors++; $display("FAIL reset_vfetch: got %0b expected 0", vf); end
        checks++; if (idx_x !== '0) begin errors++; $display("FAIL reset_exe_idx: got %0d expected 0", idx_x); end
    endtask

    task automatic test_warmup();
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (idx_f !== TW'(k % N)) begin errors++; $display("FAIL warm_counter k=%0d: got %0d expected %0d", k, idx_f, k % N); end
            checks++; if (rdy !== (k >= E + 2)) begin errors++; $display("FAIL warm_ready k=%0d: got %0b expected %0b", k, rdy, k >= E + 2); end
            checks++; if (idx_x !== TW'((k >= E) ? (k - E) % N : 0)) begin errors++; $display("FAIL warm_exe_idx k=%0d: got %0d expected %0d", k, idx_x, (k >= E) ? (k - E) % N : 0); end
            checks++; if (vx !== e_xv()) begin errors++; $display("FAIL warm_vexe k=%0d: got %0b expected %0b", k, vx, e_xv()); end
        end
    endtask

    task automatic test_boot_mask();
`ifdef SINGLE_THREAD_BOOT_EN
        checks++; if (mask !== 16'h0001) begin errors++; $display("FAIL boot_mask: got %h expected 0001", mask); end
        step(0, 0, 0, 1, 4);
        checks++; if (mask !== 16'h0011) begin errors++; $display("FAIL boot_wake4: got %h expected 0011", mask); end
        begin
            int n = 0;
            while (idx_f !== TW'(4) && n < 2 * N) begin step(0, 0, 0, 0, 0); n++; end
            checks++; if (vf !== 1'b1 || idx_f !== TW'(4)) begin errors++; $display("FAIL boot_slot4: got idx=%0d v=%0b expected idx=4 v=1", idx_f, vf); end
        end
`else
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL boot_mask: got %h expected ffff", mask); end
`endif
        // Bring every thread up; waking an active thread must be a no-op.
        for (int t = 0; t < N; t++) begin
            step(0, 0, 0, 1, t);
        end
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL wake_all: got %h expected ffff", mask); end
    endtask

    task automatic test_halt();
        int n = 0;
        while (!(idx_x === TW'(5) && vx === 1'b1) && n < 3 * N) begin step(0, 0, 0, 0, 0); n++; end
        checks++; if (idx_x !== TW'(5)) begin errors++; $display("FAIL halt_wait: got exe idx %0d expected 5", idx_x); end
        step(0, 1, 5, 0, 0);
        checks++; if (mask !== 16'hFFDF) begin errors++; $display("FAIL halt_mask: got %h expected ffdf", mask); end
        n = 0;
        while (idx_f !== TW'(5) && n < 2 * N) begin
            checks++; if (vf !== 1'b1) begin errors++; $display("FAIL halt_other_vfetch idx=%0d: got %0b expected 1", idx_f, vf); end
            step(0, 0, 0, 0, 0); n++;
        end
        checks++; if (vf !== 1'b0 || idx_f !== TW'(5)) begin errors++; $display("FAIL halt_vfetch: got idx=%0d v=%0b expected idx=5 v=0", idx_f, vf); end
        for (int i = 0; i < E; i++) step(0, 0, 0, 0, 0);
        checks++; if (idx_x !== TW'(5)) begin errors++; $display("FAIL halt_exe_idx: got %0d expected 5", idx_x); end
        checks++; if (vx !== 1'b0) begin errors++; $display("FAIL halt_vexe: got %0b expected 0", vx); end
        step(0, 0, 0, 0, 0);
        checks++; if (vx !== 1'b1) begin errors++; $display("FAIL halt_vexe_next: got %0b expected 1", vx); end
        step(0, 0, 0, 1, 5);
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL halt_rewake: got %h expected ffff", mask); end
    endtask

    task automatic test_same_cycle();
        step(0, 1, 3, 0, 0);
        checks++; if (mask !== 16'hFFF7) begin errors++; $display("FAIL halt3: got %h expected fff7", mask); end
        step(0, 1, 3, 1, 3);
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL halt_wake3: got %h expected ffff", mask); end
        step(0, 1, 9, 0, 0);
        step(0, 1, 2, 1, 9);
        checks++; if (mask !== 16'hFFFB) begin errors++; $display("FAIL halt2_wake9: got %h expected fffb", mask); end
        step(0, 1, 2, 0, 0);
        checks++; if (mask !== 16'hFFFB) begin errors++; $display("FAIL halt_inactive: got %h expected fffb", mask); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit h = ($urandom_range(0, 3) == 0);
            bit w = ($urandom_range(0, 4) == 0);
            int a = $urandom_range(0, N - 1);
            int b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, N - 1);
            step(0, h, a, w, b);
            checks++; if (idx_f !== TW'(e_cnt())) begin errors++; $display("FAIL rnd_counter i=%0d: got %0d expected %0d", i, idx_f, e_cnt()); end
            checks++; if (mask !== m_mask) begin errors++; $display("FAIL rnd_mask i=%0d: got %h expected %h", i, mask, m_mask); end
            checks++; if (vf !== e_vf()) begin errors++; $display("FAIL rnd_vfetch i=%0d: got %0b expected %0b", i, vf, e_vf()); end
            checks++; if (idx_x !== TW'(e_xi())) begin errors++; $display("FAIL rnd_exe_idx i=%0d: got %0d expected %0d", i, idx_x, e_xi()); end
            checks++; if (vx !== e_xv()) begin errors++; $display("FAIL rnd_vexe i=%0d: got %0b expected %0b", i, vx, e_xv()); end
            checks++; if (rdy !== e_rdy()) begin errors++; $display("FAIL rnd_ready i=%0d: got %0b expected %0b", i, rdy, e_rdy()); end
        end
    endtask

    task automatic test_midrun_reset();
        int n = 0;
        step(0, 1, 6, 0, 0);
        step(0, 1, 7, 0, 0);
        while (idx_f !== TW'(11) && n < 2 * N) begin step(0, 0, 0, 0, 0); n++; end
        checks++; if (idx_f !== TW'(11)) begin errors++; $display("FAIL mid_wait: got %0d expected 11", idx_f); end
        step(1, 0, 0, 0, 0);
        checks++; if (idx_f !== '0) begin errors++; $display("FAIL mid_counter: got %0d expected 0", idx_f); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b expected 0", rdy); end
        checks++; if (vx !== 1'b0) begin errors++; $display("FAIL mid_vexe: got %0b expected 0", vx); end
        checks++; if (mask !== BOOT) begin errors++; $display("FAIL mid_mask: got %h expected %h", mask, BOOT); end
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (rdy !== (k >= E + 2)) begin errors++; $display("FAIL mid_ready k=%0d: got %0b expected %0b", k, rdy, k >= E + 2); end
            checks++; if (vx !== e_xv()) begin errors++; $display("FAIL mid_vexe k=%0d: got %0b expected %0b", k, vx, e_xv()); end
            checks++; if (idx_f !== TW'(k % N)) begin errors++; $display("FAIL mid_counter k=%0d: got %0d expected %0d", k, idx_f, k % N); end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_boot_mask();
        test_halt();
        test_same_cycle();
        test_random();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
